// File: rtl/mixer_seq_if.sv
// Frame handshake bundle for mixer_seq: input frame offer and mixed result return.
interface mixer_seq_if #(
   parameter int CHANNELS = 16,
   parameter int WIDTH    = 16
);
   localparam int LOG2N = $clog2(CHANNELS);
   localparam int OUT_W = WIDTH + LOG2N;

   logic                      in_valid;
   logic                      in_ready;
   logic [CHANNELS*WIDTH-1:0] samples;
   logic [CHANNELS*8-1:0]     gains;
   logic [CHANNELS-1:0]       chan_en;
   logic                      mode;
   logic                      out_valid;
   logic                      out_ready;
   logic [OUT_W-1:0]          mixed;
   logic                      clipped;

   // master is the environment offering frames and consuming results; slave is the mixer
   modport master (
      output in_valid, samples, gains, chan_en, mode, out_ready,
      input  in_ready, out_valid, mixed, clipped
   );

   modport slave (
      input  in_valid, samples, gains, chan_en, mode, out_ready,
      output in_ready, out_valid, mixed, clipped
   );
endinterface

// File: rtl/mixer_seq.sv
// Sequential gain mixer: accumulates one weighted channel per clock, then
// presents a saturated full sum or average until the consumer takes it.
module mixer_seq #(
   parameter int CHANNELS = 16,
   parameter int WIDTH    = 16
) (
   input  logic        clk,
   input  logic        rst,
   mixer_seq_if.slave  bus
);
   localparam int LOG2N  = $clog2(CHANNELS);
   localparam int OUT_W  = WIDTH + LOG2N;
   localparam int ACC_W  = WIDTH + 1 + LOG2N;
   localparam int PROD_W = WIDTH + 8;
   localparam int TERM_W = WIDTH + 1;

   typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

   state_t                    state, state_next;
   logic                      accept, last;
   logic [CHANNELS*WIDTH-1:0] samp_q;
   logic [CHANNELS*8-1:0]     gain_q;
   logic [CHANNELS-1:0]       en_q;
   logic                      mode_q;
   logic [LOG2N-1:0]          idx;
   logic [ACC_W-1:0]          acc, sum;
   logic [PROD_W-1:0]         prod;
   logic [TERM_W-1:0]         term;
   logic [WIDTH:0]            avg;
   logic [OUT_W-1:0]          mixed_next, mixed_q;
   logic                      clip_next, clipped_q;
   logic                      in_ready_q, out_valid_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               accept     = 1'b1;
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            if (idx == LOG2N'(CHANNELS - 1)) begin
               last       = 1'b1;
               state_next = OUT;
            end
         end
         OUT: begin
            if (bus.out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // One weighted term per cycle; the shift by 7 makes gain 128 unity.
   always_comb begin
      prod = PROD_W'(samp_q[idx*WIDTH +: WIDTH]) * PROD_W'(gain_q[idx*8 +: 8]);
      term = en_q[idx] ? TERM_W'(prod >> 7) : '0;
      sum  = acc + ACC_W'(term);
      avg  = (WIDTH+1)'(sum >> LOG2N);
      if (!mode_q) begin
         clip_next  = sum[ACC_W-1];
         mixed_next = clip_next ? '1 : sum[OUT_W-1:0];
      end else begin
         clip_next  = avg[WIDTH];
         mixed_next = clip_next ? {{LOG2N{1'b0}}, {WIDTH{1'b1}}}
                                : {{LOG2N{1'b0}}, avg[WIDTH-1:0]};
      end
   end

   // NOTE: frame capture registers carry data only and are always loaded before use, so they have no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         samp_q <= bus.samples;
         gain_q <= bus.gains;
         en_q   <= bus.chan_en;
         mode_q <= bus.mode;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx         <= '0;
         acc         <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         mixed_q     <= '0;
         clipped_q   <= 1'b0;
      end else begin
         in_ready_q <= (state_next == IDLE);
         if (accept) begin
            acc <= '0;
            idx <= '0;
         end else if (state == ACCUM) begin
            acc <= sum;
            idx <= idx + LOG2N'(1);
         end
         if (last) begin
            mixed_q     <= mixed_next;
            clipped_q   <= clip_next;
            out_valid_q <= 1'b1;
         end else if (state == OUT && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.mixed     = mixed_q;
   assign bus.clipped   = clipped_q;
endmodule

// File: tb/tb_mixer_seq.sv
// Directed and randomised checks of mixer_seq at 16x16 and at a small 2x8 build.
module tb_mixer_seq;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mixer_seq_if #(.CHANNELS(16), .WIDTH(16)) bus ();
   mixer_seq_if #(.CHANNELS(2),  .WIDTH(8))  bus_s ();

   mixer_seq #(.CHANNELS(16), .WIDTH(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
   mixer_seq #(.CHANNELS(2),  .WIDTH(8))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Independent reference: straight arithmetic on wide integers.
   function automatic void ref_mix(input int ch, input int w, input logic [255:0] s,
                                   input logic [127:0] g, input logic [15:0] en,
                                   input logic md, output longint mx, output logic cl);
      longint sum, smp, gn, avg, out_max, w_max;
      int     lg;
      sum = 0;
      lg  = $clog2(ch);
      for (int k = 0; k < ch; k++) begin
         smp = 0;
         gn  = 0;
         for (int b = 0; b < w; b++) if (s[k*w+b]) smp |= longint'(1) << b;
         for (int b = 0; b < 8; b++) if (g[k*8+b]) gn |= longint'(1) << b;
         if (en[k]) sum += (smp * gn) / 128;
      end
      out_max = (longint'(1) << (w + lg)) - 1;
      w_max   = (longint'(1) << w) - 1;
      if (!md) begin
         cl = (sum > out_max);
         mx = cl ? out_max : sum;
      end else begin
         avg = sum >> lg;
         cl  = (avg > w_max);
         mx  = cl ? w_max : avg;
      end
   endfunction

   task automatic start_frame(input logic [255:0] s, input logic [127:0] g,
                              input logic [15:0] en, input logic md, output bit ok);
      int tries;
      @(negedge clk);
      bus.samples  = s;
      bus.gains    = g;
      bus.chan_en  = en;
      bus.mode     = md;
      bus.in_valid = 1'b1;
      tries = 0;
      while (bus.in_ready !== 1'b1 && tries < 50) begin
         @(negedge clk);
         tries++;
      end
      ok = (bus.in_ready === 1'b1);
      if (ok) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.samples  = ~s;
      bus.gains    = ~g;
      bus.chan_en  = ~en;
      bus.mode     = ~md;
   endtask

   task automatic wait_result(output int lat, output logic [19:0] mx, output logic cl);
      lat = -1;
      mx  = '0;
      cl  = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid === 1'b1) begin
            lat = n;
            break;
         end
      end
      if (lat > 0) begin
         mx = bus.mixed;
         cl = bus.clipped;
      end
   endtask

   task automatic release_result(input int stall);
      repeat (stall) @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic run_frame(input logic [255:0] s, input logic [127:0] g, input logic [15:0] en,
                            input logic md, input int stall,
                            output int lat, output logic [19:0] mx, output logic cl);
      bit ok;
      start_frame(s, g, en, md, ok);
      if (ok) wait_result(lat, mx, cl);
      else begin
         lat = -1;
         mx  = '0;
         cl  = 1'b0;
      end
      release_result(stall);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.mixed !== 20'h0) begin errors++; $display("FAIL reset_mixed got %h exp 0", bus.mixed); end
      checks++; if (bus.clipped !== 1'b0) begin errors++; $display("FAIL reset_clipped got %b exp 0", bus.clipped); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_early got %b exp 0", bus.in_ready); end
      @(posedge clk);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", bus.in_ready); end
   endtask

   task automatic test_unity();
      int lat; logic [19:0] mx; logic cl;
      run_frame({16{16'hFFFF}}, {16{8'd128}}, 16'hFFFF, 1'b0, 0, lat, mx, cl);
      checks++; if (lat !== 16) begin errors++; $display("FAIL unity_latency got %0d exp 16", lat); end
      checks++; if (mx !== 20'hFFFF0) begin errors++; $display("FAIL unity_mixed got %h exp FFFF0", mx); end
      checks++; if (cl !== 1'b0) begin errors++; $display("FAIL unity_clipped got %b exp 0", cl); end
   endtask

   task automatic test_clip();
      int lat; logic [19:0] mx; logic cl;
      run_frame({16{16'hFFFF}}, {16{8'd255}}, 16'hFFFF, 1'b0, 0, lat, mx, cl);
      checks++; if (lat !== 16) begin errors++; $display("FAIL clip_latency got %0d exp 16", lat); end
      checks++; if (mx !== 20'hFFFFF) begin errors++; $display("FAIL clip_mixed got %h exp FFFFF", mx); end
      checks++; if (cl !== 1'b1) begin errors++; $display("FAIL clip_clipped got %b exp 1", cl); end
   endtask

   task automatic test_average();
      int lat; logic [19:0] mx; logic cl; logic [255:0] s;
      for (int k = 0; k < 16; k++) s[k*16 +: 16] = 16'(k * 1000);
      run_frame(s, {16{8'd128}}, 16'hFFFF, 1'b1, 2, lat, mx, cl);
      checks++; if (lat !== 16) begin errors++; $display("FAIL avg_latency got %0d exp 16", lat); end
      checks++; if (mx !== 20'd7500) begin errors++; $display("FAIL avg_mixed got %0d exp 7500", mx); end
      checks++; if (cl !== 1'b0) begin errors++; $display("FAIL avg_clipped got %b exp 0", cl); end
   endtask

   task automatic test_mask();
      int lat; logic [19:0] mx; logic cl;
      run_frame({{15{16'hFFFF}}, 16'h1234}, {{15{8'd255}}, 8'd64}, 16'h0001, 1'b0, 0, lat, mx, cl);
      checks++; if (mx !== 20'd2330) begin errors++; $display("FAIL mask_mixed got %0d exp 2330", mx); end
      checks++; if (cl !== 1'b0) begin errors++; $display("FAIL mask_clipped got %b exp 0", cl); end
      run_frame({16{16'hFFFF}}, {16{8'd255}}, 16'h0000, 1'b0, 0, lat, mx, cl);
      checks++; if (lat !== 16) begin errors++; $display("FAIL no_en_latency got %0d exp 16", lat); end
      checks++; if (mx !== 20'd0) begin errors++; $display("FAIL no_en_mixed got %0d exp 0", mx); end
      checks++; if (cl !== 1'b0) begin errors++; $display("FAIL no_en_clipped got %b exp 0", cl); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [19:0] mx; logic cl; bit ok;
      start_frame({16{16'hFFFF}}, {16{8'd128}}, 16'hFFFF, 1'b0, ok);
      wait_result(lat, mx, cl);
      checks++; if (lat !== 16) begin errors++; $display("FAIL bp_latency got %0d exp 16", lat); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.samples  = {16{16'h0001}};
         bus.gains    = {16{8'd128}};
         bus.chan_en  = 16'hFFFF;
         bus.mode     = 1'b0;
         bus.in_valid = 1'b1;
         @(posedge clk);
         #1;
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got %b exp 1", i, bus.out_valid); end
         checks++; if (bus.mixed !== 20'hFFFF0) begin errors++; $display("FAIL bp_mixed[%0d] got %h exp FFFF0", i, bus.mixed); end
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, bus.in_ready); end
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.mixed !== 20'hFFFF0) begin errors++; $display("FAIL bp_hold_mixed got %h exp FFFF0", bus.mixed); end
      run_frame({16{16'h0001}}, {16{8'd128}}, 16'hFFFF, 1'b0, 0, lat, mx, cl);
      checks++; if (lat !== 16) begin errors++; $display("FAIL bp_next_latency got %0d exp 16", lat); end
      checks++; if (mx !== 20'd16) begin errors++; $display("FAIL bp_next_mixed got %0d exp 16", mx); end
   endtask

   task automatic test_reset_mid();
      int lat; logic [19:0] mx; logic cl; bit ok; bit seen; logic [255:0] s;
      start_frame({16{16'hFFFF}}, {16{8'd128}}, 16'hFFFF, 1'b0, ok);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.mixed !== 20'h0) begin errors++; $display("FAIL mid_rst_mixed got %h exp 0", bus.mixed); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b exp 0", bus.in_ready); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid === 1'b1) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_abort got out_valid pulse exp none"); end
      for (int k = 0; k < 16; k++) s[k*16 +: 16] = 16'(k * 1000);
      run_frame(s, {16{8'd128}}, 16'hFFFF, 1'b1, 0, lat, mx, cl);
      checks++; if (lat !== 16) begin errors++; $display("FAIL mid_rst_next_latency got %0d exp 16", lat); end
      checks++; if (mx !== 20'd7500) begin errors++; $display("FAIL mid_rst_next_mixed got %0d exp 7500", mx); end
   endtask

   task automatic test_random_wide();
      int lat; logic [19:0] mx; logic cl; longint emx; logic ecl;
      logic [255:0] s; logic [127:0] g; logic [15:0] en; logic md;
      for (int f = 0; f < 150; f++) begin
         for (int i = 0; i < 8; i++) s[i*32 +: 32] = $urandom;
         for (int i = 0; i < 4; i++) g[i*32 +: 32] = $urandom;
         if (f % 4 == 0) s = {256{1'b1}};
         en = 16'($urandom);
         md = 1'($urandom);
         ref_mix(16, 16, s, g, en, md, emx, ecl);
         run_frame(s, g, en, md, $urandom_range(0, 2), lat, mx, cl);
         checks++; if (lat !== 16) begin errors++; $display("FAIL rnd16_latency[%0d] got %0d exp 16", f, lat); end
         checks++; if (mx !== 20'(emx)) begin errors++; $display("FAIL rnd16_mixed[%0d] got %h exp %h", f, mx, 20'(emx)); end
         checks++; if (cl !== ecl) begin errors++; $display("FAIL rnd16_clipped[%0d] got %b exp %b", f, cl, ecl); end
      end
   endtask

   task automatic test_random_small();
      logic [15:0] s2, g2; logic [1:0] en2; logic md2; longint emx; logic ecl;
      int lat, tries, stall;
      for (int f = 0; f < 10000; f++) begin
         s2    = 16'($urandom);
         g2    = 16'($urandom);
         en2   = 2'($urandom);
         md2   = 1'($urandom);
         stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         ref_mix(2, 8, {240'd0, s2}, {112'd0, g2}, {14'd0, en2}, md2, emx, ecl);
         @(negedge clk);
         bus_s.samples  = s2;
         bus_s.gains    = g2;
         bus_s.chan_en  = en2;
         bus_s.mode     = md2;
         bus_s.in_valid = 1'b1;
         tries = 0;
         while (bus_s.in_ready !== 1'b1 && tries < 10) begin
            @(negedge clk);
            tries++;
         end
         @(posedge clk);
         #1;
         bus_s.in_valid = 1'b0;
         bus_s.samples  = ~s2;
         bus_s.gains    = ~g2;
         bus_s.chan_en  = ~en2;
         bus_s.mode     = ~md2;
         lat = -1;
         for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (bus_s.out_valid === 1'b1) begin
               lat = n;
               break;
            end
         end
         checks++; if (lat !== 2) begin errors++; $display("FAIL rnd2_latency[%0d] got %0d exp 2", f, lat); end
         if (lat > 0) begin
            checks++; if (bus_s.mixed !== 9'(emx)) begin errors++; $display("FAIL rnd2_mixed[%0d] got %0d exp %0d", f, bus_s.mixed, emx); end
            checks++; if (bus_s.clipped !== ecl) begin errors++; $display("FAIL rnd2_clipped[%0d] got %b exp %b", f, bus_s.clipped, ecl); end
            for (int i = 0; i < stall; i++) begin
               @(posedge clk);
               #1;
               checks++; if (bus_s.out_valid !== 1'b1 || bus_s.mixed !== 9'(emx)) begin
                  errors++; $display("FAIL rnd2_stall[%0d] got valid %b mixed %0d exp valid 1 mixed %0d", f, bus_s.out_valid, bus_s.mixed, emx);
               end
            end
         end
         @(negedge clk);
         bus_s.out_ready = 1'b1;
         @(posedge clk);
         #1;
         bus_s.out_ready = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.in_valid    = 1'b0;
      bus.samples     = '0;
      bus.gains       = '0;
      bus.chan_en     = '0;
      bus.mode        = 1'b0;
      bus.out_ready   = 1'b0;
      bus_s.in_valid  = 1'b0;
      bus_s.samples   = '0;
      bus_s.gains     = '0;
      bus_s.chan_en   = '0;
      bus_s.mode      = 1'b0;
      bus_s.out_ready = 1'b0;
      test_reset();
      test_unity();
      test_clip();
      test_average();
      test_mask();
      test_back_to_back();
      test_reset_mid();
      test_random_wide();
      test_random_small();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
